adc_fifo_packer: RTL
====================

ADC_FIFO_PACKER -- requirements
Module: adc_fifo_packer

Interface
REQ-001 The block SHALL have parameter RECORD_LEN, default 64, meaning samples captured per channel per trigger (even, 2..4096).
REQ-002 The block SHALL have parameter BUF_DEPTH, default 4, meaning the per-channel word buffer depth (power of two, 2..16).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk_clk  in  1  sole clock, all logic on rising edge; reset_reset_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have bs1_in  in  14  channel-0 ADC sample, valid every cycle.
REQ-005 The block SHALL have bs2_in  in  14  channel-1 ADC sample, valid every cycle.
REQ-006 The block SHALL have write_en  in  1  acquisition enable level.
REQ-007 The block SHALL have exttrg  in  1  software trigger level; the rising edge is the trigger.
REQ-008 The block SHALL have ext_rst  in  1  synchronous soft clear, active high.
REQ-009 The block SHALL have fifo0_writedata  out  32 and fifo0_write  out  1 as channel-0 write to the downstream FIFO, and fifo0_waitrequest  in  1 as the downstream stall.
REQ-010 The block SHALL have fifo1_writedata  out  32, fifo1_write  out  1 and fifo1_waitrequest  in  1, identical to REQ-009 for channel 1.
REQ-011 The block SHALL have busy  out  1, high in CAPTURE or DRAIN.
REQ-012 The block SHALL have overflow  out  1, a sticky word-drop flag.
REQ-013 The block SHALL have trig_count  out  16, the count of accepted triggers, wrapping at 0xFFFF to 0.

Function
REQ-014 The FSM SHALL have states IDLE, ARMED, CAPTURE and DRAIN.
REQ-015 IDLE SHALL go to ARMED when write_en=1, and ARMED SHALL go to IDLE when write_en=0.
REQ-016 A trigger SHALL be detected at edge k when exttrg=1 and the registered exttrg was 0 at the previous edge; detection SHALL occur only in ARMED, where it moves ARMED to CAPTURE at edge k and increments trig_count.
REQ-017 In CAPTURE, bs1_in and bs2_in SHALL be sampled at edges k+1..k+RECORD_LEN, after which the FSM SHALL go to DRAIN.
REQ-018 Every second sample per channel SHALL form one word {first, ch, 2'b00, older[13:0], newer[13:0]}, where first=1 only for the record's first word and ch=0 for bs1 and 1 for bs2.
REQ-019 Each word SHALL be pushed into its channel buffer on the edge capturing the newer sample, so the first push occurs at k+2 and each channel receives RECORD_LEN/2 words per record.
REQ-020 fifo*_write SHALL equal "buffer not empty", and fifo*_writedata SHALL be the buffer head, so fifo*_write is high from after edge k+2.
REQ-021 A pop SHALL occur on an edge where write=1 and waitrequest=0; while waitrequest=1, writedata and write SHALL hold stable.
REQ-022 A push and a pop on the same edge, including when the buffer is full, SHALL both take effect with no drop.
REQ-023 A push into a full buffer with no pop SHALL drop the new word and set overflow=1, which then holds until ext_rst or reset.
REQ-024 DRAIN SHALL go to ARMED when both buffers are empty and write_en=1, or to IDLE when both are empty and write_en=0.
REQ-025 A write_en deassertion during CAPTURE SHALL NOT abort the record.
REQ-026 Triggers in IDLE, CAPTURE or DRAIN SHALL be ignored and not counted; exttrg held high SHALL count once.
REQ-027 The two channels SHALL be independent, so a stall on one channel SHALL NOT delay the other channel's pops.
REQ-028 ext_rst=1 at an edge SHALL force IDLE, empty both buffers, clear overflow, trig_count, any partial pair and the registered exttrg, with priority over all other events on that edge.

Reset
REQ-029 reset_reset_n=0 SHALL asynchronously force: state IDLE, buffers empty, fifo0_write=fifo1_write=0, fifo0_writedata=fifo1_writedata=0, busy=0, overflow=0, trig_count=0, registered exttrg=0.
REQ-030 Reset asserted mid-record SHALL discard all buffered and partial data, and after release the block SHALL need write_en plus a new exttrg rising edge before capturing again.

Verification
REQ-031 RECORD_LEN=4, write_en=1, waitrequest=0, bs1 ramp 0x0001,0x0002,...; one trigger -> fifo0 words 0x80004002 then 0x0000C004; fifo1 words have bit30=1; trig_count=1; busy falls after the last pop.
REQ-032 fifo0_waitrequest=1 held for 20 cycles during capture with RECORD_LEN=64, BUF_DEPTH=4 -> fifo0 writedata stable while stalled, overflow=1, fifo1 receives all 32 words unaffected.
REQ-033 Push and pop on the same edge with the buffer full (waitrequest toggling 1,0) -> no word lost and overflow stays 0.
REQ-034 Second exttrg edge during CAPTURE, then exttrg held high across DRAIN into ARMED -> trig_count increments only once, and one record is produced.
REQ-035 write_en=0 at sample 10 of 64 -> full record still emitted and FSM ends in IDLE; ext_rst pulse mid-DRAIN -> write=0 next cycle, overflow=0, trig_count=0.
REQ-036 reset_reset_n low between clock edges during CAPTURE -> all outputs at REQ-029 values immediately, with no clock edge required.

Source files
------------

// File: rtl/adc_fifo_packer_if.sv
`default_nettype none
// adc_fifo_packer_if: the two downstream FIFO write ports of the ADC packer, one per channel.
interface adc_fifo_packer_if;
  logic [31:0] fifo0_writedata;
  logic        fifo0_write;
  logic        fifo0_waitrequest;
  logic [31:0] fifo1_writedata;
  logic        fifo1_write;
  logic        fifo1_waitrequest;

  modport master (
    output fifo0_writedata, fifo0_write, fifo1_writedata, fifo1_write,
    input  fifo0_waitrequest, fifo1_waitrequest
  );

  modport slave (
    input  fifo0_writedata, fifo0_write, fifo1_writedata, fifo1_write,
    output fifo0_waitrequest, fifo1_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/adc_fifo_packer.sv
`default_nettype none
// adc_fifo_packer: triggered two-channel ADC capture; packs sample pairs into 32-bit words
// and streams them through small per-channel buffers to the downstream FIFOs.
module adc_fifo_packer #(
  parameter int RECORD_LEN = 64,
  parameter int BUF_DEPTH  = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [13:0]       bs1_in,
  input  logic [13:0]       bs2_in,
  input  logic              write_en,
  input  logic              exttrg,
  input  logic              ext_rst,
  adc_fifo_packer_if.master fifo,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       trig_count
);
  localparam int CW = $clog2(RECORD_LEN);
  localparam int PW = $clog2(BUF_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          exttrg_q, exttrg_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   trig_count_q, trig_count_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          capture, last_sample, trig, push, first;
  logic [1:0]    waitreq, nonempty, drop;
  logic [13:0]   sample [2];
  logic [31:0]   head [2];

  assign waitreq     = {fifo.fifo1_waitrequest, fifo.fifo0_waitrequest};
  assign sample[0]   = bs1_in;
  assign sample[1]   = bs2_in;
  assign capture     = (state_q == S_CAPTURE);
  assign last_sample = (cnt_q == CW'(RECORD_LEN - 1));
  assign trig        = (state_q == S_ARMED) & write_en & exttrg & ~exttrg_q;
  // cnt_q is the index of the sample taken this edge; odd indices complete a pair
  assign push        = capture & cnt_q[0];
  assign first       = (cnt_q == CW'(1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (write_en) state_d = S_ARMED;
      S_ARMED:   if (!write_en) state_d = S_IDLE;
                 else if (trig) state_d = S_CAPTURE;
      S_CAPTURE: if (last_sample) state_d = S_DRAIN;
      S_DRAIN:   if (nonempty == 2'b00) state_d = write_en ? S_ARMED : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (ext_rst) state_d = S_IDLE;
  end

  always_comb begin
    busy = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
  end

  always_comb begin
    exttrg_d     = ext_rst ? 1'b0 : exttrg;
    overflow_d   = ext_rst ? 1'b0 : (overflow_q | (|drop));
    trig_count_d = ext_rst ? 16'd0 : (trig ? trig_count_q + 16'd1 : trig_count_q);
    cnt_d        = '0;
    if (!ext_rst && capture && !last_sample) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      exttrg_q     <= 1'b0;
      overflow_q   <= 1'b0;
      trig_count_q <= 16'd0;
      cnt_q        <= '0;
    end else begin
      exttrg_q     <= exttrg_d;
      overflow_q   <= overflow_d;
      trig_count_q <= trig_count_d;
      cnt_q        <= cnt_d;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    localparam logic CH_BIT = 1'(ch);

    logic [31:0]   mem_q [BUF_DEPTH];
    logic [31:0]   mem_d [BUF_DEPTH];
    logic [13:0]   older_q, older_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   fill_q, fill_d;
    logic          pop, full, accept;
    logic [31:0]   word;

    assign full          = (fill_q == (PW+1)'(BUF_DEPTH));
    assign pop           = (fill_q != '0) & ~waitreq[ch];
    // a full buffer still accepts when its head leaves on the same edge
    assign accept        = push & (~full | pop);
    assign drop[ch]      = push & full & ~pop;
    assign word          = {first, CH_BIT, 2'b00, older_q, sample[ch]};
    assign nonempty[ch]  = (fill_q != '0);
    assign head[ch]      = nonempty[ch] ? mem_q[rd_ptr_q] : 32'd0;

    always_comb begin
      mem_d    = mem_q;
      older_d  = older_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (ext_rst) begin
        older_d  = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        fill_d   = '0;
      end else begin
        if (capture && !cnt_q[0]) older_d = sample[ch];
        if (accept) begin
          mem_d[wr_ptr_q] = word;
          wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        fill_d = fill_q + (PW+1)'(accept) - (PW+1)'(pop);
      end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        older_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        fill_q   <= '0;
      end else begin
        mem_q    <= mem_d;
        older_q  <= older_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        fill_q   <= fill_d;
      end
    end
  end

  assign fifo.fifo0_writedata = head[0];
  assign fifo.fifo0_write     = nonempty[0];
  assign fifo.fifo1_writedata = head[1];
  assign fifo.fifo1_write     = nonempty[1];
  assign overflow             = overflow_q;
  assign trig_count           = trig_count_q;
endmodule
`default_nettype wire
